// File: rtl/bram_burst_arbiter.sv
// Round-robin burst arbiter sharing one BRAM port between two requesters.
// Generates sequential wrapping addresses, streams write data and returns read data.
module bram_burst_arbiter #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int MEM_SIZE = 3840,
  parameter int LWIDTH   = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              req_we_0,
  input  logic              req_we_1,
  input  logic [AWIDTH-1:0] req_addr_0,
  input  logic [AWIDTH-1:0] req_addr_1,
  input  logic [LWIDTH-1:0] req_len_0,
  input  logic [LWIDTH-1:0] req_len_1,
  output logic              req_ack_0,
  output logic              req_ack_1,
  input  logic [DWIDTH-1:0] wr_data_0,
  input  logic [DWIDTH-1:0] wr_data_1,
  output logic              wr_ready_0,
  output logic              wr_ready_1,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid_0,
  output logic              rd_valid_1,
  output logic              done_0,
  output logic              done_1,
  output logic              err,
  output logic              bram_ce,
  output logic              bram_we,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [DWIDTH-1:0] bram_d,
  input  logic [DWIDTH-1:0] bram_q,
  output logic [1:0]        state_dbg
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              last_grant;
  logic              id_q;
  logic              we_q;
  logic              err_pending;
  logic [AWIDTH-1:0] cur_addr;
  logic [LWIDTH-1:0] cnt;

  logic              grant_v;
  logic              grant_id;
  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [LWIDTH-1:0] sel_len;
  logic              addr_ok;
  logic              in_burst;
  logic              in_drain;

  // Handshake: req_x is held high until the one-cycle req_ack_x pulse; requests
  // are only sampled in IDLE. While wr_ready_x is high the requester must present
  // a new beat every cycle; rd_valid_x qualifies rd_data for exactly one cycle.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = 1'b0;
    if (state == IDLE) begin
      if (req_0 && req_1) begin
        grant_v  = 1'b1;
        grant_id = ~last_grant;
      end else if (req_0) begin
        grant_v  = 1'b1;
      end else if (req_1) begin
        grant_v  = 1'b1;
        grant_id = 1'b1;
      end
    end
    sel_we   = grant_id ? req_we_1   : req_we_0;
    sel_addr = grant_id ? req_addr_1 : req_addr_0;
    sel_len  = grant_id ? req_len_1  : req_len_0;
    addr_ok  = (sel_addr <= LAST_ADDR);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_v) state_nx = (addr_ok && (sel_len != '0)) ? BURST : DRAIN;
      BURST:   if (cnt == LWIDTH'(1)) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_burst  = (state == BURST);
  assign in_drain  = (state == DRAIN);
  assign state_dbg = state;

  assign bram_ce    = in_burst;
  assign bram_we    = in_burst & we_q;
  assign bram_addr  = in_burst ? cur_addr : '0;
  assign bram_d     = (in_burst & we_q) ? (id_q ? wr_data_1 : wr_data_0) : '0;
  assign wr_ready_0 = in_burst & we_q & ~id_q;
  assign wr_ready_1 = in_burst & we_q & id_q;
  assign done_0     = in_drain & ~id_q;
  assign done_1     = in_drain & id_q;
  assign err        = in_drain & err_pending;
  assign rd_data    = bram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      err_pending <= 1'b0;
      cur_addr    <= '0;
      cnt         <= '0;
      req_ack_0   <= 1'b0;
      req_ack_1   <= 1'b0;
      rd_valid_0  <= 1'b0;
      rd_valid_1  <= 1'b0;
    end else begin
      state      <= state_nx;
      req_ack_0  <= grant_v & ~grant_id;
      req_ack_1  <= grant_v & grant_id;
      // BRAM read latency is one cycle, so the valid trails the read beat.
      rd_valid_0 <= in_burst & ~we_q & ~id_q;
      rd_valid_1 <= in_burst & ~we_q & id_q;
      if (grant_v) begin
        id_q        <= grant_id;
        we_q        <= sel_we;
        cur_addr    <= sel_addr;
        cnt         <= sel_len;
        last_grant  <= grant_id;
        err_pending <= ~addr_ok;
      end else if (in_burst) begin
        cnt      <= cnt - LWIDTH'(1);
        cur_addr <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + AWIDTH'(1);
      end else if (in_drain) begin
        err_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_burst_arbiter.sv
// Bench for bram_burst_arbiter: directed scenarios plus random bursts, checked
// by a scoreboard fed from a burst-level model of the two requesters and memory.
module tb_bram_burst_arbiter;

  localparam int MEM_SIZE = 3840;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1, req_we_0, req_we_1;
  logic [11:0] req_addr_0, req_addr_1;
  logic [12:0] req_len_0, req_len_1;
  logic        req_ack_0, req_ack_1;
  logic [15:0] wr_data_0, wr_data_1;
  logic        wr_ready_0, wr_ready_1;
  logic [15:0] rd_data;
  logic        rd_valid_0, rd_valid_1, done_0, done_1, err;
  logic        bram_ce, bram_we;
  logic [11:0] bram_addr;
  logic [15:0] bram_d, bram_q;
  logic [1:0]  state_dbg;

  bram_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .req_we_0(req_we_0), .req_we_1(req_we_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_len_0(req_len_0), .req_len_1(req_len_1),
    .req_ack_0(req_ack_0), .req_ack_1(req_ack_1),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
    .wr_ready_0(wr_ready_0), .wr_ready_1(wr_ready_1),
    .rd_data(rd_data), .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
    .done_0(done_0), .done_1(done_1), .err(err),
    .bram_ce(bram_ce), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_d(bram_d), .bram_q(bram_q), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // BRAM array behind the shared port
  logic [15:0] bram [MEM_SIZE];
  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_we) bram[bram_addr] <= bram_d;
      else         bram_q <= bram[bram_addr];
    end
  end

  // reference model state
  logic [15:0] ref_mem [MEM_SIZE];
  logic [15:0] wd0[$], wd1[$];
  int          tag_m = 0;
  int          last_m = 1;

  // scoreboard: acc {tag8,id,we,addr12,d16}, rd {tag8,id,d16}, done {tag8,id,err}, ack {tag8,id}
  logic [37:0] acc_q[$];
  logic [24:0] rd_q[$];
  logic [9:0]  done_q[$];
  logic [8:0]  ack_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] wd_at(input int id, input int k);
    return (id == 0) ? wd0[k] : wd1[k];
  endfunction

  function automatic logic ack_of(input int id);
    return (id == 0) ? req_ack_0 : req_ack_1;
  endfunction

  function automatic logic done_of(input int id);
    return (id == 0) ? done_0 : done_1;
  endfunction

  function automatic logic wr_ready_of(input int id);
    return (id == 0) ? wr_ready_0 : wr_ready_1;
  endfunction

  task automatic fill_wd(input int id, input int len);
    if (id == 0) wd0.delete(); else wd1.delete();
    for (int i = 0; i < len; i++) begin
      if (id == 0) wd0.push_back(16'($urandom));
      else         wd1.push_back(16'($urandom));
    end
  endtask

  // Burst-level model: the beats of a granted burst walk addr, addr+1, ... mod MEM_SIZE.
  task automatic model_burst(input int id, input bit we, input int addr, input int len);
    logic [7:0]  tg;
    logic        idb;
    logic [15:0] d;
    int          a;
    tag_m++;
    tg  = 8'(tag_m);
    idb = (id != 0);
    ack_q.push_back({tg, idb});
    if (addr < MEM_SIZE) begin
      for (int i = 0; i < len; i++) begin
        a = (addr + i) % MEM_SIZE;
        if (we) begin
          d = wd_at(id, i);
          ref_mem[a] = d;
        end else begin
          d = ref_mem[a];
          rd_q.push_back({tg, idb, d});
        end
        acc_q.push_back({tg, idb, we, 12'(a), we ? d : 16'h0});
      end
    end
    done_q.push_back({tg, idb, addr >= MEM_SIZE});
    last_m = id;
  endtask

  // driver tasks
  task automatic set_req(input int id, input bit v, input bit we, input int addr, input int len);
    if (id == 0) begin
      req_0 = v; req_we_0 = we; req_addr_0 = 12'(addr); req_len_0 = 13'(len);
    end else begin
      req_1 = v; req_we_1 = we; req_addr_1 = 12'(addr); req_len_1 = 13'(len);
    end
  endtask

  task automatic set_wd(input int id, input logic [15:0] d);
    if (id == 0) wr_data_0 = d; else wr_data_1 = d;
  endtask

  task automatic run_burst(input int id, input bit we, input int addr, input int len,
                           output int ack_cyc);
    bit got;
    int k, guard, exp_gap;
    bit ok_addr;
    ok_addr = (addr < MEM_SIZE);
    set_wd(id, (we && len > 0) ? wd_at(id, 0) : 16'h0);
    set_req(id, 1'b1, we, addr, len);
    got = 1'b0;
    ack_cyc = -1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = ack_of(id);
    end
    if (!got) begin
      check("ack_timeout", 1, 0);
      set_req(id, 1'b0, 1'b0, 0, 0);
      return;
    end
    ack_cyc = cyc;
    set_req(id, 1'b0, 1'b0, 0, 0);
    k = 0;
    guard = 0;
    while (we && ok_addr && k < len && guard < len + 4) begin
      if (wr_ready_of(id)) k++;
      guard++;
      @(posedge clk);
      #1;
      if (k < len) set_wd(id, wd_at(id, k));
      @(negedge clk);
    end
    got = done_of(id);
    for (int t = 0; t < len + 20 && !got; t++) begin
      @(negedge clk);
      got = done_of(id);
    end
    exp_gap = (len > 0 && ok_addr) ? len : 0;
    check("done_latency", got ? 64'(cyc - ack_cyc) : 64'hdead, 64'(exp_gap));
    set_wd(id, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
    set_wd(0, 16'h0);
    set_wd(1, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_m = 1;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an output
  logic [37:0] m_acc;
  logic [24:0] m_rd;
  logic [9:0]  m_done;
  logic [8:0]  m_ack;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bram_ce) begin
        if (acc_q.size() == 0) check("unexpected_access", 1, 0);
        else begin
          m_acc = acc_q.pop_front();
          check("bram_access",
                {bram_we, bram_addr, bram_we ? bram_d : 16'h0, wr_ready_1, wr_ready_0},
                {m_acc[28], m_acc[27:16], m_acc[15:0], m_acc[28] & m_acc[29], m_acc[28] & ~m_acc[29]});
        end
      end else begin
        check("idle_strobes", {bram_we, wr_ready_1, wr_ready_0}, 0);
      end
      if (rd_valid_0 && rd_valid_1) check("rd_valid_both", 1, 0);
      else if (rd_valid_0 || rd_valid_1) begin
        if (rd_q.size() == 0) check("unexpected_rd_valid", 1, 0);
        else begin
          m_rd = rd_q.pop_front();
          check("rd_return", {rd_valid_1, rd_data}, {m_rd[16], m_rd[15:0]});
        end
      end
      if (req_ack_0 && req_ack_1) check("ack_both", 1, 0);
      else if (req_ack_0 || req_ack_1) begin
        if (ack_q.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          m_ack = ack_q.pop_front();
          check("ack_id", req_ack_1, m_ack[0]);
        end
      end
      if (done_0 && done_1) check("done_both", 1, 0);
      else if (done_0 || done_1) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          m_done = done_q.pop_front();
          check("done_id_err", {done_1, err}, {m_done[1], m_done[0]});
          if (acc_q.size() > 0) check("beats_after_done", acc_q[0][37:30] <= m_done[9:2], 0);
          if (rd_q.size() > 0)  check("rd_after_done", rd_q[0][24:17] <= m_done[9:2], 0);
        end
      end else begin
        check("err_idle", err, 0);
      end
    end
  end

  // stimulus
  int c0, c1;
  int a_r, l_r, a_s, l_s, mode, first;
  bit w_r, w_s;

  task automatic gen(output bit we, output int addr, output int len);
    int r;
    we = 1'($urandom_range(0, 1));
    r  = $urandom_range(0, 9);
    if (r == 0)      addr = MEM_SIZE + $urandom_range(0, 255);
    else if (r == 1) addr = MEM_SIZE - 10 + $urandom_range(0, 9);
    else             addr = $urandom_range(0, MEM_SIZE - 1);
    len = $urandom_range(0, 12);
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
    wr_data_0 = '0;
    wr_data_1 = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      ref_mem[i] = 16'($urandom);
      bram[i]    = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {req_ack_0, req_ack_1, wr_ready_0, wr_ready_1, rd_valid_0, rd_valid_1,
           done_0, done_1, err, bram_ce, bram_we, bram_addr, bram_d, state_dbg}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // write then read back, single requester
    wd0 = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    model_burst(0, 1'b1, 'h010, 4);
    run_burst(0, 1'b1, 'h010, 4, c0);
    model_burst(0, 1'b0, 'h010, 4);
    run_burst(0, 1'b0, 'h010, 4, c0);

    // simultaneous requests after reset, twice
    do_reset();
    for (int p = 0; p < 2; p++) begin
      model_burst(0, 1'b0, 'h010, 2);
      model_burst(1, 1'b0, 'h100, 2);
      fork
        run_burst(0, 1'b0, 'h010, 2, c0);
        run_burst(1, 1'b0, 'h100, 2, c1);
      join
      check("pair_spacing", 64'(c1 - c0), 4);
    end

    // wrap-around read
    model_burst(1, 1'b0, 3838, 4);
    run_burst(1, 1'b0, 3838, 4, c1);

    // zero length and out-of-range base
    model_burst(0, 1'b0, 5, 0);
    run_burst(0, 1'b0, 5, 0, c0);
    fill_wd(1, 3);
    model_burst(1, 1'b1, MEM_SIZE, 3);
    run_burst(1, 1'b1, MEM_SIZE, 3, c1);

    // reset in the middle of an 8-beat write; only 3 beats ever reach the port
    fill_wd(0, 8);
    tag_m++;
    ack_q.push_back({8'(tag_m), 1'b0});
    for (int i = 0; i < 3; i++) begin
      ref_mem['h200 + i] = wd0[i];
      acc_q.push_back({8'(tag_m), 1'b0, 1'b1, 12'('h200 + i), wd0[i]});
    end
    set_wd(0, wd0[0]);
    set_req(0, 1'b1, 1'b1, 'h200, 8);
    c0 = 0;
    for (int t = 0; t < 20 && c0 == 0; t++) begin
      @(negedge clk);
      if (req_ack_0) c0 = 1;
    end
    check("rst_test_ack", c0, 1);
    set_req(0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rst = 1'b1;
      else begin
        @(posedge clk);
        #1;
        set_wd(0, wd0[k + 1]);
        @(negedge clk);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    set_wd(0, 16'h0);
    last_m = 1;
    check("rst_mid_burst_state", {state_dbg, bram_ce, done_0, wr_ready_0}, 0);
    repeat (3) @(negedge clk);
    model_burst(1, 1'b0, 'h200, 3);
    run_burst(1, 1'b0, 'h200, 3, c1);

    // requester 1 holds its request through requester 0's burst
    fill_wd(0, 5);
    model_burst(0, 1'b1, 'h300, 5);
    model_burst(1, 1'b0, 'h300, 5);
    fork
      run_burst(0, 1'b1, 'h300, 5, c0);
      begin
        @(negedge clk);
        run_burst(1, 1'b0, 'h300, 5, c1);
      end
    join
    check("isolation_spacing", 64'(c1 - c0), 7);

    // random traffic
    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      gen(w_r, a_r, l_r);
      if (mode < 2) begin
        fill_wd(mode, l_r);
        model_burst(mode, w_r, a_r, l_r);
        run_burst(mode, w_r, a_r, l_r, c0);
      end else begin
        gen(w_s, a_s, l_s);
        fill_wd(0, l_r);
        fill_wd(1, l_s);
        first = (last_m == 1) ? 0 : 1;
        if (first == 0) begin
          model_burst(0, w_r, a_r, l_r);
          model_burst(1, w_s, a_s, l_s);
        end else begin
          model_burst(1, w_s, a_s, l_s);
          model_burst(0, w_r, a_r, l_r);
        end
        fork
          run_burst(0, w_r, a_r, l_r, c0);
          run_burst(1, w_s, a_s, l_s, c1);
        join
      end
    end

    repeat (4) @(negedge clk);
    check("acc_q_empty", acc_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
